// File: rtl/dac_tdm_drv.sv
// I2S / TDM serializer for NUM_CH channels with a one-frame-ahead FIFO fetch and underrun muting.
// Optional underrun counter enabled by defining DAC_TDM_DRV_UNDERRUN_CNT_EN.
module dac_tdm_drv #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int BCK_DIV    = 8
) (
    input  logic                  clk245760,
    input  logic                  rst,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ack_i,
    output logic                  pop_o,
    output logic                  bck_o,
    output logic                  lrck_o,
    output logic                  data_o,
    output logic                  underrun_o
`ifdef DAC_TDM_DRV_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt_o
`endif
);

    localparam int DIV_W  = $clog2(BCK_DIV);
    localparam int POS_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int FILL_W = $clog2(NUM_CH + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } fetch_state_t;

    fetch_state_t          state;
    logic [DIV_W-1:0]      div_cnt;
    logic [POS_W-1:0]      pos_cnt;
    logic [CH_W-1:0]       slot_cnt;
    logic                  mode_r;
    logic [FILL_W-1:0]     fill;
    logic [DATA_WIDTH-1:0] fill_buf  [NUM_CH];
    logic [DATA_WIDTH-1:0] frame_buf [NUM_CH];

    logic                  wrap;
    logic                  pos_last;
    logic                  slot_last;
    logic                  frame_start;
    logic                  full;
    logic                  store;
    logic                  mode_nxt;
    logic                  lrck_nxt;
    logic                  bit_nxt;
    logic [DIV_W-1:0]      div_nxt;
    logic [POS_W-1:0]      pos_nxt;
    logic [CH_W-1:0]       slot_nxt;
    logic [DATA_WIDTH-1:0] word_nxt;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        wrap        = (div_cnt == DIV_W'(BCK_DIV - 1));
        pos_last    = (pos_cnt == POS_W'(SLOT_WIDTH - 1));
        slot_last   = (slot_cnt == CH_W'(NUM_CH - 1));
        frame_start = wrap && pos_last && slot_last;
        full        = (fill == FILL_W'(NUM_CH));
        store       = (state == S_WAIT) && ack_i;
        div_nxt     = wrap ? '0 : div_cnt + DIV_W'(1);
        pos_nxt     = pos_last ? '0 : pos_cnt + POS_W'(1);
        slot_nxt    = slot_cnt;
        if (pos_last) begin
            slot_nxt = slot_last ? '0 : slot_cnt + CH_W'(1);
        end
        mode_nxt = frame_start ? mode_i : mode_r;
    end

    // Output bit for the upcoming bck period, taken from the buffer as it will be after this edge.
    always_comb begin
        word_nxt = frame_buf[slot_nxt];
        if (frame_start) begin
            word_nxt = full ? fill_buf[slot_nxt] : '0;
        end
        shifted = '0;
        bit_nxt = 1'b0;
        if (mode_nxt) begin
            if (int'(pos_nxt) < DATA_WIDTH) begin
                shifted = word_nxt << pos_nxt;
                bit_nxt = shifted[DATA_WIDTH-1];
            end
        end else if (pos_nxt != '0 && int'(pos_nxt) <= DATA_WIDTH) begin
            shifted = word_nxt << (pos_nxt - POS_W'(1));
            bit_nxt = shifted[DATA_WIDTH-1];
        end
        lrck_nxt = mode_nxt ? frame_start : (int'(slot_nxt) >= NUM_CH / 2);
    end

    always_ff @(posedge clk245760) begin
        if (rst) begin
            div_cnt    <= '0;
            pos_cnt    <= '0;
            slot_cnt   <= '0;
            mode_r     <= 1'b0;
            bck_o      <= 1'b0;
            lrck_o     <= 1'b0;
            data_o     <= 1'b0;
            underrun_o <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                frame_buf[ch] <= '0;
            end
        end else begin
            div_cnt    <= div_nxt;
            bck_o      <= (int'(div_nxt) >= BCK_DIV / 2);
            underrun_o <= frame_start && !full;
            if (wrap) begin
                pos_cnt  <= pos_nxt;
                slot_cnt <= slot_nxt;
                data_o   <= bit_nxt;
                lrck_o   <= lrck_nxt;
            end
            if (frame_start) begin
                mode_r <= mode_i;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    frame_buf[ch] <= full ? fill_buf[ch] : '0;
                end
            end
        end
    end

    // Fetch FSM: at most one pop in flight; an ack landing on the frame-start edge opens the new fill.
    always_ff @(posedge clk245760) begin
        if (rst) begin
            state <= S_IDLE;
            pop_o <= 1'b0;
            fill  <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                fill_buf[ch] <= '0;
            end
        end else begin
            pop_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!full) begin
                        pop_o <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (frame_start) begin
                fill <= store ? FILL_W'(1) : '0;
                if (store) begin
                    fill_buf[0] <= data_i;
                end
            end else if (store) begin
                fill                <= fill + FILL_W'(1);
                fill_buf[CH_W'(fill)] <= data_i;
            end
        end
    end

`ifdef DAC_TDM_DRV_UNDERRUN_CNT_EN
    always_ff @(posedge clk245760) begin
        if (rst) begin
            underrun_cnt_o <= '0;
        end else if (frame_start && !full && underrun_cnt_o != 16'hffff) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_tdm_drv.sv
// Randomized bench for dac_tdm_drv: a cycle-count based frame model predicts every output each cycle.
// Honours DAC_TDM_DRV_UNDERRUN_CNT_EN when the design is built with it.
module tb_dac_tdm_drv;

  localparam int DW   = 24;
  localparam int SW   = 32;
  localparam int NC   = 2;
  localparam int BD   = 8;
  localparam int FB   = NC * SW;
  localparam int FC   = FB * BD;
  localparam int MAXF = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode_i = 1'b0;
  logic          ack_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          pop, bck, lrck, sdata, und;
`ifdef DAC_TDM_DRV_UNDERRUN_CNT_EN
  logic [15:0]   und_cnt;
`endif

  dac_tdm_drv #(
    .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .NUM_CH(NC), .BCK_DIV(BD)
  ) dut (
    .clk245760(clk), .rst(rst), .mode_i(mode_i), .data_i(data_i), .ack_i(ack_i),
    .pop_o(pop), .bck_o(bck), .lrck_o(lrck), .data_o(sdata), .underrun_o(und)
`ifdef DAC_TDM_DRV_UNDERRUN_CNT_EN
    , .underrun_cnt_o(und_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  int  n = 0;
  bit  in_rst = 1'b1;
  int  phase = 0;
  int  epoch = 0;
  bit  drop_acks = 1'b1;
  bit  ack_real = 1'b0;
  bit  outstanding = 1'b0;
  int  cd = 0;
  int  seq_idx = 0;
  int  exp_cnt = 0;
  logic [DW-1:0] seq_val [2] = '{24'h800001, 24'h7fffff};
  logic [DW-1:0] win_data [MAXF][NC];
  int  win_cnt [MAXF];
  bit  frame_mode [MAXF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (n=%0d epoch=%0d)", name, act, exp, n, epoch);
    end
  endtask

  // Model bookkeeping: which samples were accepted in which frame window, and each frame's mode.
  always @(posedge clk) begin
    in_rst = rst;
    if (rst) begin
      n = 0;
      exp_cnt = 0;
      for (int w = 0; w < MAXF; w++) win_cnt[w] = 0;
    end else begin
      n++;
      if (n % FC == 0 && n / FC < MAXF) begin
        frame_mode[n / FC] = mode_i;
        if (win_cnt[n / FC - 1] != NC && exp_cnt < 65535) exp_cnt++;
      end
      if (ack_real && n / FC < MAXF) begin
        if (win_cnt[n / FC] < NC) win_data[n / FC][win_cnt[n / FC]] = data_i;
        win_cnt[n / FC]++;
      end
    end
  end

  // Driver: answers pops after a delay, occasionally very late; injects stray acks while idle.
  always @(negedge clk) begin
    bit was;
    was = outstanding;
    ack_i = 1'b0;
    ack_real = 1'b0;
    data_i = DW'($urandom);
    if (in_rst) begin
      outstanding = 1'b0;
      cd = 0;
    end else begin
      if (pop) check("pop_while_outstanding", 32'(was), 32'd0);
      if (was && !drop_acks) begin
        cd--;
        if (cd <= 0) begin
          ack_i = 1'b1;
          ack_real = 1'b1;
          outstanding = 1'b0;
          if (phase == 1) begin
            data_i = seq_val[seq_idx % 2];
            seq_idx++;
          end
        end
      end else if (!was && !pop && phase == 2 && $urandom_range(0, 49) == 0) begin
        ack_i = 1'b1;
      end
      if (pop) begin
        outstanding = 1'b1;
        if (phase == 1) cd = 2;
        else if ($urandom_range(0, 15) == 0) cd = $urandom_range(100, 700);
        else cd = $urandom_range(1, 6);
      end
    end
  end

  // Scoreboard: expected outputs from frame/bit position derived from the cycle count.
  always @(posedge clk) begin
    int f, b, s, p, m;
    bit full;
    logic [DW-1:0] word;
    logic e_data, e_lrck, e_und;
    #1;
    if (!in_rst) begin
      f = n / FC;
      b = (n / BD) % FB;
      s = b / SW;
      p = b % SW;
      m = (f == 0) ? 0 : int'(frame_mode[f]);
      full = (f > 0) && (win_cnt[f-1] == NC);
      word = full ? win_data[f-1][s] : '0;
      e_data = 1'b0;
      if (m == 1) begin
        if (p < DW) e_data = word[DW-1-p];
        e_lrck = (b == 0);
      end else begin
        if (p >= 1 && p <= DW) e_data = word[DW-p];
        e_lrck = (s >= NC / 2);
      end
      e_und = (n % FC == 0) && (f > 0) && !full;
      check("bck", 32'(bck), 32'((n % BD) >= BD / 2));
      check("data", 32'(sdata), 32'(e_data));
      check("lrck", 32'(lrck), 32'(e_lrck));
      check("underrun", 32'(und), 32'(e_und));
`ifdef DAC_TDM_DRV_UNDERRUN_CNT_EN
      check("underrun_cnt", 32'(und_cnt), 32'(exp_cnt));
      if (epoch == 0 && n == 5 * FC - 1) check("lit_cnt_after_5_frames", 32'(und_cnt), 32'd4);
`endif
      // hand-computed pins of the model
      if (epoch == 0) begin
        if (n == FC) check("lit_und_frame1", 32'(und), 32'd1);
        if (n == FC + 1) check("lit_und_pulse_len", 32'(und), 32'd0);
        if (n == FC - 1) check("lit_no_und_frame0", 32'(und), 32'd0);
        if (n == 32 * BD + 4) check("lit_idle_lrck_hi", 32'(lrck), 32'd1);
      end
      if (epoch == 1) begin
        if (n >= FC && n < 2 * FC && n % BD == 4) begin
          case (b)
            0, 2, 23, 25, 31, 32, 33, 57: check("lit_i2s_zero_bit", 32'(sdata), 32'd0);
            1, 24, 34, 56:                check("lit_i2s_one_bit", 32'(sdata), 32'd1);
            default: ;
          endcase
          if (b == 31) check("lit_i2s_lrck_left", 32'(lrck), 32'd0);
          if (b == 32) check("lit_i2s_lrck_right", 32'(lrck), 32'd1);
        end
        if (n == 2 * FC + 32 * BD + 4) check("lit_toggle_frame_still_i2s", 32'(lrck), 32'd1);
        if (n == 3 * FC + 4) begin
          check("lit_tdm_fsync", 32'(lrck), 32'd1);
          check("lit_tdm_msb", 32'(sdata), 32'd1);
        end
        if (n == 3 * FC + BD + 4) check("lit_tdm_fsync_low", 32'(lrck), 32'd0);
        if (n == 3 * FC + 23 * BD + 4) check("lit_tdm_lsb", 32'(sdata), 32'd1);
      end
    end
  end

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 60000) begin
      @(negedge clk);
      guard++;
      if (phase == 2 && $urandom_range(0, 599) == 0) mode_i = ~mode_i;
    end
    if (n < target) check("wait_timeout", 32'(n), 32'(target));
  endtask

  task automatic reset_checks();
    check("rst_bck", 32'(bck), 32'd0);
    check("rst_lrck", 32'(lrck), 32'd0);
    check("rst_data", 32'(sdata), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_underrun", 32'(und), 32'd0);
`ifdef DAC_TDM_DRV_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", 32'(und_cnt), 32'd0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_checks();
    // idle, no acks: underrun from frame 1 onward
    rst = 1'b0;
    wait_n(5 * FC - 1);
    rst = 1'b1;
    @(negedge clk);
    reset_checks();
    // fixed L/R samples, prompt acks, mode raised mid-frame 2
    phase = 1;
    drop_acks = 1'b0;
    seq_idx = 0;
    epoch = 1;
    rst = 1'b0;
    wait_n(2 * FC + 10 * BD);
    mode_i = 1'b1;
    wait_n(3 * FC);
    // random data, delays, stray acks and mode toggles
    phase = 2;
    wait_n(13 * FC + 137);
    rst = 1'b1;
    @(negedge clk);
    reset_checks();
    epoch = 2;
    rst = 1'b0;
    wait_n(4 * FC + 50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_tdm_drv.md
Name: dac_tdm_drv

Overview:
Parametrised successor to the stereo DAC serializer. Runs in the clk245760 domain and serializes NUM_CH channels of DATA_WIDTH-bit samples onto a bck/lrck/data triplet, in either I2S (2-channel, lrck 50% duty) or TDM (frame-sync pulse) mode. Fetches samples from the upstream async FIFO read side with a pop/ack handshake, one frame ahead. Explicitly detects and flags underruns; an underrun frame is muted.

Parameters:
DATA_WIDTH, 24, sample width in bits (1..SLOT_WIDTH)
SLOT_WIDTH, 32, bck cycles per channel slot
NUM_CH, 2, channels per frame (even, 2..8)
BCK_DIV, 8, clk245760 cycles per bck period (even, >=2)

Ports:
clk245760  in  1  system clock
rst  in  1  reset, synchronous, active-high
mode_i  in  1  0 = I2S, 1 = TDM; sampled only at frame start
data_i  in  DATA_WIDTH  sample from FIFO, valid when ack_i=1
ack_i  in  1  one-cycle strobe answering a pop_o
pop_o  out  1  one-cycle request for the next sample
bck_o  out  1  bit clock
lrck_o  out  1  word clock (I2S) / frame sync (TDM)
data_o  out  1  serial data, MSB first
underrun_o  out  1  one-cycle pulse at the start of a muted frame
underrun_cnt_o  out  16  underrun counter (only with the optional feature)

Behaviour:
- Reset values: bck_o=0, lrck_o=0, data_o=0, pop_o=0, underrun_o=0. All counters 0, fill=0, no pop outstanding, active mode=I2S.
- Divider div_cnt counts 0..BCK_DIV-1. bck_o=0 for div_cnt<BCK_DIV/2, else 1. data_o/lrck_o change only when div_cnt wraps to 0 (bck falling edge).
- Bit counter bit_cnt counts 0..NUM_CH*SLOT_WIDTH-1, advancing when div_cnt wraps. Frame start is bit_cnt wrapping to 0.
- Frame start actions, in the same cycle:
  - latch mode_i;
  - if fill==NUM_CH, copy the fill buffer to the shift buffer; otherwise load zeros and pulse underrun_o;
  - fill:=0.
  - underrun_o is suppressed for the first frame after reset.
- Slot bit mapping: slot s = bit_cnt/SLOT_WIDTH, position p = bit_cnt%SLOT_WIDTH.
  - I2S: data_o = bit (DATA_WIDTH-1-(p-1)) of channel s for 1<=p<=DATA_WIDTH, else 0. The MSB is delayed by 1 bck; for s=0, p=0, data_o carries the LSB-slot padding 0.
  - TDM: no delay; data_o = bit (DATA_WIDTH-1-p) for p<DATA_WIDTH, else 0.
- lrck_o:
  - I2S: 0 while s<NUM_CH/2, 1 otherwise.
  - TDM: 1 only during bit_cnt==0, else 0.
- Fetch FSM, states IDLE/WAIT:
  - IDLE: if fill<NUM_CH, assert pop_o for 1 cycle and go to WAIT.
  - WAIT: on ack_i, store data_i at fill index, fill+1, return to IDLE.
- At most one pop is outstanding. Max pop rate is one per 2 cycles.
- ack_i while IDLE: ignored.
- ack_i in the same cycle as frame start: the sample is stored as index 0 of the new fill (the clear takes priority, then the store, so fill=1).
- An outstanding pop survives a frame boundary.
- Channel order: the first accepted sample after frame start is channel 0.
- Mode change takes effect only at the next frame start; mid-frame mode_i toggles have no effect.
- rst mid-frame: all state returns to reset values on the next edge, and the pending pop is abandoned.

Optional Feature:
DAC_TDM_DRV_UNDERRUN_CNT_EN
- Defined: underrun_cnt_o is present as a 16-bit counter. It increments on each underrun_o pulse, saturates at 16'hffff, and is cleared by rst.
- Undefined: the port and counter are absent; underrun_o is unchanged.

Test Plan:
- Reset then idle, no acks: bck_o toggles with period 8 cycles, lrck_o low for 32 bck and high for 32 bck, data_o=0. No underrun_o in frame 0; underrun_o=1 for 1 cycle at the start of frame 1.
- I2S, NUM_CH=2, acks 2 cycles after each pop with L=24'h800001 and R=24'h7fffff:
  - next frame data_o is 0, then 1, 0×22, 1, then 0×7 padding (left);
  - then 0, then 0, 1×23, then 0×7 (right);
  - lrck_o edge precedes the MSB by 1 bck.
- TDM, NUM_CH=8, 8 samples 24'h000001..24'h000008 delivered: lrck_o is high for bck 0 only, and slot k carries value k+1 with no delay. Frame length is 256 bck.
- Only 1 of 2 acks delivered before the frame boundary: the next frame outputs all zeros, underrun_o pulses once, the late ack lands in channel 0, and the following frame is correct.
- mode_i toggled from 0 to 1 at bit_cnt=10: the current frame stays I2S and the next frame is TDM.
- With DAC_TDM_DRV_UNDERRUN_CNT_EN, no acks for 5 frames after reset: underrun_cnt_o=4. After rst, underrun_cnt_o=0.
